// File: rtl/gshare_br_predictor_if.sv
// Signal bundle between the fetch/resolve pipeline and the gshare predictor.
interface gshare_br_predictor_if #(
    parameter int unsigned HIST_BITS = 8
);
    logic                 stall;
    logic [31:0]          pc;
    logic [6:0]           opcode;
    logic                 predict_dir;
    logic [HIST_BITS-1:0] predict_ghr;
    logic [6:0]           ex_mem_opcode;
    logic [31:0]          ex_mem_pc;
    logic                 ex_mem_br_en;
    logic [HIST_BITS-1:0] ex_mem_ghr;
    logic                 ex_mem_mispredict;
    logic                 clear;
    logic                 busy;

    modport master (
        output stall, pc, opcode, ex_mem_opcode, ex_mem_pc, ex_mem_br_en, ex_mem_ghr,
        output ex_mem_mispredict, clear,
        input  predict_dir, predict_ghr, busy
    );

    modport slave (
        input  stall, pc, opcode, ex_mem_opcode, ex_mem_pc, ex_mem_br_en, ex_mem_ghr,
        input  ex_mem_mispredict, clear,
        output predict_dir, predict_ghr, busy
    );
endinterface

// File: rtl/gshare_br_predictor.sv
// Gshare direction predictor: PC xor global history indexes a table of saturating counters.
// The table is (re)initialised by a one-entry-per-cycle sweep after reset or clear.
module gshare_br_predictor #(
    parameter int unsigned IDX_BITS  = 9,
    parameter int unsigned HIST_BITS = 8,
    parameter int unsigned CTR_BITS  = 2
) (
    input logic                  clk,
    input logic                  rst,
    gshare_br_predictor_if.slave bp
);
    localparam logic [6:0] OpBr   = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;
    localparam logic [6:0] OpJalr = 7'b1100111;

    localparam int unsigned        Entries = 2 ** IDX_BITS;
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CtrMax  = '1;

    typedef enum logic {StInit, StRun} state_e;

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  sweep_q, sweep_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [CTR_BITS-1:0]  pht_q [Entries];

    logic [IDX_BITS-1:0]  fetch_idx, upd_idx, wr_idx;
    logic [CTR_BITS-1:0]  upd_cur, upd_ctr, wr_val;
    logic                 wr_en, fetch_is_jump, fetch_is_br, ex_is_br;
    logic [HIST_BITS:0]   spec_shift, rec_shift;
    logic                 unused_pc_bits;

    assign fetch_idx     = bp.pc[IDX_BITS+1:2] ^ IDX_BITS'(ghr_q);
    assign upd_idx       = bp.ex_mem_pc[IDX_BITS+1:2] ^ IDX_BITS'(bp.ex_mem_ghr);
    assign fetch_is_jump = (bp.opcode == OpJal) || (bp.opcode == OpJalr);
    assign fetch_is_br   = (bp.opcode == OpBr);
    assign ex_is_br      = (bp.ex_mem_opcode == OpBr);

    // One extra bit on the left lets the shift drop the oldest bit for any HIST_BITS >= 1.
    assign spec_shift = {ghr_q, bp.predict_dir};
    assign rec_shift  = {bp.ex_mem_ghr, bp.ex_mem_br_en};

    assign upd_cur = pht_q[upd_idx];
    always_comb begin
        upd_ctr = upd_cur;
        if (bp.ex_mem_br_en) begin
            if (upd_cur != CtrMax) upd_ctr = upd_cur + 1'b1;
        end else begin
            if (upd_cur != '0) upd_ctr = upd_cur - 1'b1;
        end
    end

    // Table read happens before the edge, so a same-index write is seen only next cycle.
    assign bp.predict_dir = fetch_is_jump || ((state_q == StRun) && pht_q[fetch_idx][CTR_BITS-1]);
    assign bp.predict_ghr = ghr_q;
    assign bp.busy        = (state_q == StInit);

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ghr_d   = ghr_q;
        wr_en   = 1'b0;
        wr_idx  = sweep_q;
        wr_val  = CtrInit;
        unique case (state_q)
            StInit: begin
                wr_en   = 1'b1;
                sweep_d = sweep_q + 1'b1;
                ghr_d   = '0;
                if (sweep_q == '1) state_d = StRun;
            end
            StRun: begin
                if (bp.clear) begin
                    state_d = StInit;
                    sweep_d = '0;
                    ghr_d   = '0;
                end else if (!bp.stall) begin
                    if (ex_is_br) begin
                        wr_en  = 1'b1;
                        wr_idx = upd_idx;
                        wr_val = upd_ctr;
                    end
                    if (bp.ex_mem_mispredict) begin
                        ghr_d = ex_is_br ? rec_shift[HIST_BITS-1:0] : bp.ex_mem_ghr;
                    end else if (fetch_is_br) begin
                        ghr_d = spec_shift[HIST_BITS-1:0];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StInit;
            sweep_q <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ghr_q   <= ghr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) pht_q[wr_idx] <= wr_val;
    end

    assign unused_pc_bits = ^{bp.pc[31:IDX_BITS+2], bp.pc[1:0],
                              bp.ex_mem_pc[31:IDX_BITS+2], bp.ex_mem_pc[1:0]};
endmodule

// File: tb/tb_gshare_br_predictor.sv
// Directed bench for gshare_br_predictor with IDX_BITS=4, HIST_BITS=4, CTR_BITS=2.
module tb_gshare_br_predictor;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cnt;

    gshare_br_predictor_if #(.HIST_BITS(4)) bp ();

    gshare_br_predictor #(
        .IDX_BITS (4),
        .HIST_BITS(4),
        .CTR_BITS (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bp.stall = 1'b0; bp.pc = '0; bp.opcode = '0; bp.clear = 1'b0;
        bp.ex_mem_opcode = '0; bp.ex_mem_pc = '0; bp.ex_mem_br_en = 1'b0;
        bp.ex_mem_ghr = '0; bp.ex_mem_mispredict = 1'b0;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [31:0] a);
        bp.opcode = op; bp.pc = a;
    endtask

    task automatic resolve(input logic [6:0] op, input logic [31:0] a, input logic [3:0] g,
                           input logic en, input logic mis);
        bp.ex_mem_opcode = op; bp.ex_mem_pc = a; bp.ex_mem_ghr = g;
        bp.ex_mem_br_en = en; bp.ex_mem_mispredict = mis;
    endtask

    // Looks at the prediction for a branch without letting it shift the GHR at the next edge.
    task automatic peek(input string tag, input logic [31:0] a, input logic exp);
        fetch(OP_BR, a);
        #1 chk(tag, 32'(bp.predict_dir), 32'(exp));
        bp.opcode = '0;
    endtask

    logic [31:0] res_pc [11] = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40, 32'h40,
                                 32'h54, 32'h54, 32'h54, 32'h54};
    logic        res_en [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b1};
    logic        pk     [8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        idle();
        #2;
        chk("rst_busy", 32'(bp.busy), 32'd1);
        chk("rst_ghr", 32'(bp.predict_ghr), 32'd0);
        bp.opcode = OP_BR;
        #1 chk("rst_pdir_br", 32'(bp.predict_dir), 32'd0);
        bp.opcode = OP_JAL;
        #1 chk("rst_pdir_jal", 32'(bp.predict_dir), 32'd1);
        idle();

        // Initial sweep length
        @(negedge clk);
        rst = 1'b1;
        cnt = 0;
        #1;
        while (bp.busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("init_busy_len", 32'(cnt), 32'd16);
        peek("init_pdir_40", 32'h40, 1'b0);
        peek("init_pdir_3c", 32'h3C, 1'b0);
        chk("init_ghr", 32'(bp.predict_ghr), 32'd0);

        // Train entry 0 (with saturation both ways) then entry 5
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 7) peek($sformatf("train_e0_%0d", i), 32'h40, pk[i]);
            resolve(OP_BR, res_pc[i], 4'h0, res_en[i], 1'b0);
        end
        @(negedge clk);
        idle();
        peek("train_e5_sat", 32'h54, 1'b1);
        peek("train_e0_final", 32'h40, 1'b1);
        chk("train_ghr", 32'(bp.predict_ghr), 32'd0);

        // Speculative history: predictions 1,0,1
        @(negedge clk); fetch(OP_BR, 32'h40);
        #1 chk("spec_p0", 32'(bp.predict_dir), 32'd1);
        @(negedge clk); fetch(OP_BR, 32'h40);
        #1 chk("spec_p1", 32'(bp.predict_dir), 32'd0);
        @(negedge clk); fetch(OP_BR, 32'h08);
        #1 chk("spec_p2", 32'(bp.predict_dir), 32'd1);
        @(negedge clk); idle();
        #1 chk("spec_ghr", 32'(bp.predict_ghr), 32'h5);

        // Stall freezes history and table writes
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bp.stall = 1'b1;
            fetch(OP_BR, 32'h40 + 32'(i * 4));
            resolve(OP_BR, 32'h54, 4'h0, 1'b0, 1'b0);
        end
        @(negedge clk); idle();
        #1 chk("stall_ghr", 32'(bp.predict_ghr), 32'h5);

        // Recovery beats a same-cycle speculative shift; entry 5 untouched by stalled writes
        @(negedge clk);
        fetch(OP_BR, 32'h40);
        resolve(OP_BR, 32'h40, 4'h3, 1'b0, 1'b1);
        #1 chk("rec_pdir_e5", 32'(bp.predict_dir), 32'd1);
        @(negedge clk); idle();
        #1 chk("rec_br_ghr", 32'(bp.predict_ghr), 32'h6);

        // Jumps: always taken, never shift; jalr recovery restores the captured GHR
        fetch(OP_JAL, 32'h1C);
        #1 chk("jal_pdir", 32'(bp.predict_dir), 32'd1);
        @(negedge clk);
        #1 chk("jal_ghr", 32'(bp.predict_ghr), 32'h6);
        fetch(OP_JALR, 32'h1C);
        resolve(OP_JALR, 32'h100, 4'h9, 1'b0, 1'b1);
        #1 chk("jalr_pdir", 32'(bp.predict_dir), 32'd1);
        @(negedge clk); idle();
        #1 chk("jalr_rec_ghr", 32'(bp.predict_ghr), 32'h9);

        // Same-index read and write: prediction uses the pre-write counter
        fetch(OP_BR, 32'h20);
        resolve(OP_BR, 32'h04, 4'h0, 1'b1, 1'b0);
        #1 chk("rw_pdir_prewrite", 32'(bp.predict_dir), 32'd0);
        @(negedge clk); idle();
        #1 chk("rw_ghr", 32'(bp.predict_ghr), 32'h2);
        peek("rw_pdir_postwrite", 32'h0C, 1'b1);

        // Clear: priority over updates, 16-cycle sweep, resolutions and re-clear ignored
        @(negedge clk);
        bp.clear = 1'b1;
        fetch(OP_BR, 32'h40);
        resolve(OP_BR, 32'h40, 4'h3, 1'b1, 1'b1);
        #1 chk("clr_busy_before", 32'(bp.busy), 32'd0);
        @(negedge clk);
        bp.clear = 1'b0;
        resolve(OP_BR, 32'h00, 4'h0, 1'b1, 1'b1);
        #1 chk("clr_ghr_zero", 32'(bp.predict_ghr), 32'd0);
        cnt = 0;
        while (bp.busy && cnt < 100) begin
            cnt++;
            bp.clear = (cnt == 5);
            @(negedge clk);
            #1;
        end
        idle();
        chk("clr_busy_len", 32'(cnt), 32'd16);
        chk("clr_ghr_after", 32'(bp.predict_ghr), 32'd0);
        bp.stall = 1'b1;
        for (int i = 0; i < 16; i++) begin
            fetch(OP_BR, 32'(i * 4));
            #1 chk($sformatf("clr_entry_%0d", i), 32'(bp.predict_dir), 32'd0);
        end
        idle();

        // Asynchronous reset in RUN
        @(negedge clk);
        resolve(OP_JALR, 32'h0, 4'hA, 1'b0, 1'b1);
        @(negedge clk); idle();
        #1 chk("pre_rst_ghr", 32'(bp.predict_ghr), 32'hA);
        #1 rst = 1'b0;
        #1 chk("async_rst_busy", 32'(bp.busy), 32'd1);
        chk("async_rst_ghr", 32'(bp.predict_ghr), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
